alu_exec_sequencer: RTL

- Multi-cycle controller that sequences the shared register bank and ALU.
- Accepts one register-register instruction (rs1, rs2, rd, opcode) on a valid/ready handshake, then:
  - drives the bank read addresses,
  - captures operands and drives the ALU,
  - writes the result back,
  - presents the result on a valid/ready output.
- Also drives the 16-bit FPGA display with the last result, alternating upper and lower halves.

---
 rtl/alu_exec_sequencer.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_sequencer.sv
// -----------------------------------------------------------------------------
// alu_exec_sequencer
//
// Multi-cycle controller that runs one register-register instruction at a time
// through a shared register bank and an external combinational ALU:
//   IDLE -> READ -> EXEC -> WB -> DONE -> IDLE
// The bank is read combinationally in READ. The operands are registered into
// the ALU inputs at the READ->EXEC edge. The result is staged for write-back at
// the EXEC->WB edge and written during WB. It is then held on the result port
// until the consumer takes it. A free-running divider alternates the 16-bit
// display between the lower and upper half of the last result.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   instr_*           instruction handshake and fields (rs1, rs2, rd, op, wb)
//   rb_read_reg1/2    bank read addresses      rb_data_out1/2  bank read data
//   rb_write_*        bank write address, data and strobe
//   alu_a/b/opcode    ALU operands and opcode  alu_result      ALU result
//   res_valid/ready   result handshake         res_data        result value
//   op_count          completed instructions (wraps at 16 bits)
//   display           selected half of res_data, registered
// -----------------------------------------------------------------------------
module alu_exec_sequencer #(
    parameter int unsigned DISP_DIV = 50000000,
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned DW       = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [3:0]        instr_op,
    input  logic              instr_wb,

    output logic [REG_AW-1:0] rb_read_reg1,
    output logic [REG_AW-1:0] rb_read_reg2,
    input  logic [DW-1:0]     rb_data_out1,
    input  logic [DW-1:0]     rb_data_out2,
    output logic [REG_AW-1:0] rb_write_reg,
    output logic [DW-1:0]     rb_write_data,
    output logic              rb_write_enable,

    output logic [DW-1:0]     alu_a,
    output logic [DW-1:0]     alu_b,
    output logic [3:0]        alu_opcode,
    input  logic [DW-1:0]     alu_result,

    output logic              res_valid,
    input  logic              res_ready,
    output logic [DW-1:0]     res_data,

    output logic [15:0]       op_count,
    output logic [15:0]       display
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_DONE
    } state_e;

    // Divider width is sized to hold DISP_DIV-1 (DISP_DIV >= 2).
    localparam int unsigned      DIV_W    = $clog2(DISP_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DISP_DIV - 1);

    state_e state_q, state_d;

    // Latched instruction fields
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [3:0]        op_q, op_d;
    logic              wb_q, wb_d;

    // Datapath registers driving the outputs
    logic [REG_AW-1:0] rb_read_reg1_q, rb_read_reg1_d;
    logic [REG_AW-1:0] rb_read_reg2_q, rb_read_reg2_d;
    logic [DW-1:0]     alu_a_q, alu_a_d;
    logic [DW-1:0]     alu_b_q, alu_b_d;
    logic [3:0]        alu_opcode_q, alu_opcode_d;
    logic [REG_AW-1:0] rb_write_reg_q, rb_write_reg_d;
    logic [DW-1:0]     rb_write_data_q, rb_write_data_d;
    logic [DW-1:0]     res_data_q, res_data_d;
    logic [15:0]       op_count_q, op_count_d;

    // Display divider and half select (0 = lower half, 1 = upper half)
    logic [DIV_W-1:0]  div_q, div_d;
    logic              half_q, half_d;
    logic [15:0]       display_q, display_d;

    // -------------------------------------------------------------------------
    // FSM: next state and handshake/strobe outputs
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        state_d         = state_q;
        instr_ready     = 1'b0;
        res_valid       = 1'b0;
        rb_write_enable = 1'b0;

        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                // A reset landing on this edge aborts the instruction, so the
                // strobe is suppressed and the bank never sees the write.
                rb_write_enable = wb_q && !rst;
                state_d         = S_DONE;
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is updated only with non-blocking assignments
        // so every register samples its inputs from before the clock edge.
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath next-state
    // -------------------------------------------------------------------------
    always_comb begin
        rd_d            = rd_q;
        op_d            = op_q;
        wb_d            = wb_q;
        rb_read_reg1_d  = rb_read_reg1_q;
        rb_read_reg2_d  = rb_read_reg2_q;
        alu_a_d         = alu_a_q;
        alu_b_d         = alu_b_q;
        alu_opcode_d    = alu_opcode_q;
        rb_write_reg_d  = rb_write_reg_q;
        rb_write_data_d = rb_write_data_q;
        res_data_d      = res_data_q;
        op_count_d      = op_count_q;

        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    // Read addresses are loaded on accept so they are already
                    // on the bank in READ and stay put until the next accept.
                    rb_read_reg1_d = instr_rs1;
                    rb_read_reg2_d = instr_rs2;
                    rd_d           = instr_rd;
                    op_d           = instr_op;
                    wb_d           = instr_wb;
                end
            end
            S_READ: begin
                alu_a_d      = rb_data_out1;
                alu_b_d      = rb_data_out2;
                alu_opcode_d = op_q;
            end
            S_EXEC: begin
                // Operands are stable through WB, so the staged write data
                // matches the result captured into res_data one cycle later.
                rb_write_reg_d  = rd_q;
                rb_write_data_d = alu_result;
            end
            S_WB: begin
                res_data_d = alu_result;
            end
            S_DONE: begin
                if (res_ready) begin
                    op_count_d = op_count_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Display divider: runs independently of the FSM
    // -------------------------------------------------------------------------
    always_comb begin
        div_d  = div_q + DIV_W'(1);
        half_d = half_q;
        if (div_q == DIV_LAST) begin
            div_d  = '0;
            half_d = ~half_q;
        end
        display_d = half_q ? res_data_q[31:16] : res_data_q[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q            <= '0;
            op_q            <= '0;
            wb_q            <= 1'b0;
            rb_read_reg1_q  <= '0;
            rb_read_reg2_q  <= '0;
            alu_a_q         <= '0;
            alu_b_q         <= '0;
            alu_opcode_q    <= '0;
            rb_write_reg_q  <= '0;
            rb_write_data_q <= '0;
            res_data_q      <= '0;
            op_count_q      <= '0;
            div_q           <= '0;
            half_q          <= 1'b0;
            display_q       <= '0;
        end else begin
            rd_q            <= rd_d;
            op_q            <= op_d;
            wb_q            <= wb_d;
            rb_read_reg1_q  <= rb_read_reg1_d;
            rb_read_reg2_q  <= rb_read_reg2_d;
            alu_a_q         <= alu_a_d;
            alu_b_q         <= alu_b_d;
            alu_opcode_q    <= alu_opcode_d;
            rb_write_reg_q  <= rb_write_reg_d;
            rb_write_data_q <= rb_write_data_d;
            res_data_q      <= res_data_d;
            op_count_q      <= op_count_d;
            div_q           <= div_d;
            half_q          <= half_d;
            display_q       <= display_d;
        end
    end

    assign rb_read_reg1  = rb_read_reg1_q;
    assign rb_read_reg2  = rb_read_reg2_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_opcode    = alu_opcode_q;
    assign rb_write_reg  = rb_write_reg_q;
    assign rb_write_data = rb_write_data_q;
    assign res_data      = res_data_q;
    assign op_count      = op_count_q;
    assign display       = display_q;

endmodule
